// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Shared definitions for the NS/EW intersection phase scheduler:
//   - phase_t   : phase codes 0..5 (codes 6 and 7 are illegal)
//   - lamps_t   : lamp vector {NS_r, NS_y, NS_g, EW_r, EW_y, EW_g}
//   - lamp_decode(): phase -> lamp vector
//   - DEF_*     : default timing constants
// -----------------------------------------------------------------------------
package traffic_pkg;

    typedef enum logic [2:0] {
        AR_TO_NS = 3'd0,
        NS_GRN   = 3'd1,
        NS_YEL   = 3'd2,
        AR_TO_EW = 3'd3,
        EW_GRN   = 3'd4,
        EW_YEL   = 3'd5
    } phase_t;

    // {NS_r, NS_y, NS_g, EW_r, EW_y, EW_g}
    typedef logic [5:0] lamps_t;

    localparam int DEF_CNT_W    = 5;
    localparam int DEF_NS_MIN   = 5;
    localparam int DEF_NS_MAX   = 20;
    localparam int DEF_EW_MIN   = 3;
    localparam int DEF_EW_MAX   = 12;
    localparam int DEF_YELLOW_T = 3;
    localparam int DEF_ALLRED_T = 1;

    // Illegal codes decode to both-red so the lamps stay safe even for the
    // single cycle before the FSM recovers.
    function automatic lamps_t lamp_decode(input phase_t ph);
        lamps_t l;
        case (ph)
            NS_GRN:  l = 6'b001_100;
            NS_YEL:  l = 6'b010_100;
            EW_GRN:  l = 6'b100_001;
            EW_YEL:  l = 6'b100_010;
            default: l = 6'b100_100;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/traffic_phase_sched_if.sv
// -----------------------------------------------------------------------------
// traffic_phase_sched_if
// Groups the detect inputs, lamp outputs and debug status of the scheduler.
//   NS_vehicle_detect / EW_vehicle_detect : demand levels (master -> slave)
//   NS_red/yellow/green, EW_red/yellow/green : lamps (slave -> master)
//   o_phase : current phase code, o_timer : cycles elapsed in phase
// slave  : the scheduler side
// master : the environment driving demand and observing lamps
// -----------------------------------------------------------------------------
interface traffic_phase_sched_if #(
    parameter int CNT_W = 5
);
    logic             NS_vehicle_detect;
    logic             EW_vehicle_detect;
    logic             NS_red;
    logic             NS_yellow;
    logic             NS_green;
    logic             EW_red;
    logic             EW_yellow;
    logic             EW_green;
    logic [2:0]       o_phase;
    logic [CNT_W-1:0] o_timer;

    modport master (
        output NS_vehicle_detect, EW_vehicle_detect,
        input  NS_red, NS_yellow, NS_green,
        input  EW_red, EW_yellow, EW_green,
        input  o_phase, o_timer
    );

    modport slave (
        input  NS_vehicle_detect, EW_vehicle_detect,
        output NS_red, NS_yellow, NS_green,
        output EW_red, EW_yellow, EW_green,
        output o_phase, o_timer
    );
endinterface

// File: rtl/phase_timer.sv
// -----------------------------------------------------------------------------
// phase_timer
// CNT_W-bit saturating up-counter with synchronous clear.
//   i_clk   : clock
//   i_rst_n : synchronous active-low reset (count -> 0)
//   clr     : synchronous clear (count -> 0)
//   count   : current count, holds at all-ones
// -----------------------------------------------------------------------------
module phase_timer #(
    parameter int CNT_W = 5
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || clr) begin
            count <= '0;
        end else if (count != '1) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/traffic_phase_sched.sv
// -----------------------------------------------------------------------------
// traffic_phase_sched
// Phase scheduler for an NS/EW intersection. A single phase timer times
// green, yellow and all-red; right-of-way is arbitrated from vehicle demand
// using min-green, gap-out and max-out rules.
//   i_clk   : clock
//   i_rst_n : synchronous active-low reset
//   bus     : traffic_phase_sched_if.slave (detects in; lamps, phase, timer out)
// -----------------------------------------------------------------------------
module traffic_phase_sched
    import traffic_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int NS_MIN   = DEF_NS_MIN,
    parameter int NS_MAX   = DEF_NS_MAX,
    parameter int EW_MIN   = DEF_EW_MIN,
    parameter int EW_MAX   = DEF_EW_MAX,
    parameter int YELLOW_T = DEF_YELLOW_T,
    parameter int ALLRED_T = DEF_ALLRED_T
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    traffic_phase_sched_if.slave bus
);

    // Thresholds are the last timer value of each interval (duration - 1).
    localparam logic [CNT_W-1:0] NS_MIN_L = CNT_W'(NS_MIN - 1);
    localparam logic [CNT_W-1:0] NS_MAX_L = CNT_W'(NS_MAX - 1);
    localparam logic [CNT_W-1:0] EW_MIN_L = CNT_W'(EW_MIN - 1);
    localparam logic [CNT_W-1:0] EW_MAX_L = CNT_W'(EW_MAX - 1);
    localparam logic [CNT_W-1:0] YEL_L    = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] AR_L     = CNT_W'(ALLRED_T - 1);

    phase_t           phase;
    phase_t           next_phase;
    logic             ns_pend;
    logic             ew_pend;
    logic             ns_opp;
    logic             ew_opp;
    logic             phase_change;
    logic [CNT_W-1:0] timer;
    lamps_t           lamps;

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .clr     (phase_change),
        .count   (timer)
    );

    // Opposing demand is the latched request or the live detect, so a car
    // arriving during our own green is seen in the same cycle.
    always_comb begin
        next_phase = phase;
        ns_opp     = ew_pend | bus.EW_vehicle_detect;
        ew_opp     = ns_pend | bus.NS_vehicle_detect;
        case (phase)
            AR_TO_NS: if (timer == AR_L) next_phase = NS_GRN;
            NS_GRN: begin
                if (ns_opp && ((timer >= NS_MIN_L && !bus.NS_vehicle_detect) ||
                               timer >= NS_MAX_L))
                    next_phase = NS_YEL;
            end
            NS_YEL:   if (timer == YEL_L) next_phase = AR_TO_EW;
            AR_TO_EW: if (timer == AR_L) next_phase = EW_GRN;
            EW_GRN: begin
                if (ew_opp && ((timer >= EW_MIN_L && !bus.EW_vehicle_detect) ||
                               timer >= EW_MAX_L))
                    next_phase = EW_YEL;
            end
            EW_YEL:   if (timer == YEL_L) next_phase = AR_TO_NS;
            default:  next_phase = AR_TO_NS;
        endcase
    end

    assign phase_change = (next_phase != phase);

    // Lamps are registered from next_phase so they always equal the decode
    // of the phase register, with no path from the detect inputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            phase   <= AR_TO_NS;
            ns_pend <= 1'b0;
            ew_pend <= 1'b0;
            lamps   <= lamp_decode(AR_TO_NS);
        end else begin
            phase <= next_phase;
            lamps <= lamp_decode(next_phase);

            // Entry to green serves the demand, so clear wins over set.
            if (next_phase == NS_GRN && phase != NS_GRN)
                ns_pend <= 1'b0;
            else if (bus.NS_vehicle_detect && phase != NS_GRN)
                ns_pend <= 1'b1;

            if (next_phase == EW_GRN && phase != EW_GRN)
                ew_pend <= 1'b0;
            else if (bus.EW_vehicle_detect && phase != EW_GRN)
                ew_pend <= 1'b1;
        end
    end

    assign bus.NS_red    = lamps[5];
    assign bus.NS_yellow = lamps[4];
    assign bus.NS_green  = lamps[3];
    assign bus.EW_red    = lamps[2];
    assign bus.EW_yellow = lamps[1];
    assign bus.EW_green  = lamps[0];
    assign bus.o_phase   = phase;
    assign bus.o_timer   = timer;

endmodule

// File: tb/tb_traffic_phase_sched.sv
// -----------------------------------------------------------------------------
// tb_traffic_phase_sched
// Directed bench for traffic_phase_sched. Inputs change and outputs are
// sampled on the falling edge; expected phase/timer/lamp values are
// hand-derived from the phase timing rules.
// -----------------------------------------------------------------------------
module tb_traffic_phase_sched;

    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    traffic_phase_sched_if #(.CNT_W(5)) bus ();

    traffic_phase_sched #(
        .CNT_W    (5),
        .NS_MIN   (5),
        .NS_MAX   (20),
        .EW_MIN   (3),
        .EW_MAX   (12),
        .YELLOW_T (3),
        .ALLRED_T (1)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // {NS_r, NS_y, NS_g, EW_r, EW_y, EW_g}
    function automatic logic [5:0] lamp_exp(input int ph);
        case (ph)
            1:       return 6'b001100;
            2:       return 6'b010100;
            4:       return 6'b100001;
            5:       return 6'b100010;
            default: return 6'b100100;
        endcase
    endfunction

    task automatic check_state(input string tag, input int ph, input int tm);
        logic [5:0] l;
        l = {bus.NS_red, bus.NS_yellow, bus.NS_green,
             bus.EW_red, bus.EW_yellow, bus.EW_green};
        chk({tag, ".phase"}, 32'(bus.o_phase), 32'(ph));
        chk({tag, ".timer"}, 32'(bus.o_timer), 32'(tm));
        chk({tag, ".lamps"}, 32'(l), 32'(lamp_exp(ph)));
        chk({tag, ".ns_onehot"}, 32'($onehot(l[5:3])), 32'd1);
        chk({tag, ".ew_onehot"}, 32'($onehot(l[2:0])), 32'd1);
        chk({tag, ".both_go"}, 32'(!l[5] && !l[2]), 32'd0);
    endtask

    task automatic seg(input string tag, input int ph, input int n);
        for (int i = 0; i < n; i++) begin
            check_state(tag, ph, i);
            @(negedge i_clk);
        end
    endtask

    initial begin
        bus.NS_vehicle_detect = 1'b0;
        bus.EW_vehicle_detect = 1'b0;

        // 1: reset 3 cycles, no demand -> rest in NS green, timer saturates
        i_rst_n = 1'b0;
        repeat (3) @(negedge i_clk);
        check_state("t1_rst", 0, 0);
        chk("t1_rst.ns_pend", 32'(dut.ns_pend), 32'd0);
        chk("t1_rst.ew_pend", 32'(dut.ew_pend), 32'd0);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        for (int i = 0; i < 40; i++) begin
            check_state("t1_rest", 1, (i < 31) ? i : 31);
            @(negedge i_clk);
        end

        // 2: EW pulse at NS timer=1 -> NS green 5, yellow 3, all-red 1, EW green
        i_rst_n = 1'b0;
        @(negedge i_clk);
        check_state("t2_rst", 0, 0);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check_state("t2_nsg", 1, 0);
        @(negedge i_clk);
        check_state("t2_nsg", 1, 1);
        bus.EW_vehicle_detect = 1'b1;
        @(negedge i_clk);
        check_state("t2_nsg", 1, 2);
        chk("t2.ew_pend_set", 32'(dut.ew_pend), 32'd1);
        bus.EW_vehicle_detect = 1'b0;
        @(negedge i_clk);
        check_state("t2_nsg", 1, 3);
        @(negedge i_clk);
        check_state("t2_nsg", 1, 4);
        @(negedge i_clk);
        seg("t2_nsy", 2, 3);
        seg("t2_are", 3, 1);
        check_state("t2_ewg", 4, 0);
        chk("t2.ew_pend_clr", 32'(dut.ew_pend), 32'd0);

        // 4: NS held, EW detect drops at timer=5 -> EW green exactly 6 cycles
        for (int i = 0; i < 6; i++) begin
            check_state("t4_ewg", 4, i);
            bus.NS_vehicle_detect = 1'b1;
            bus.EW_vehicle_detect = (i < 5);
            @(negedge i_clk);
        end

        // 6: NS demand latched through EW yellow; set/clear collision on NS entry
        bus.NS_vehicle_detect = 1'b0;
        bus.EW_vehicle_detect = 1'b0;
        check_state("t6_ewy", 5, 0);
        @(negedge i_clk);
        check_state("t6_ewy", 5, 1);
        chk("t6.ns_pend_held", 32'(dut.ns_pend), 32'd1);
        @(negedge i_clk);
        check_state("t6_ewy", 5, 2);
        @(negedge i_clk);
        check_state("t6_arn", 0, 0);
        bus.NS_vehicle_detect = 1'b1;
        bus.EW_vehicle_detect = 1'b1;
        @(negedge i_clk);
        check_state("t6_nsg", 1, 0);
        chk("t6.ns_pend_collide", 32'(dut.ns_pend), 32'd0);
        chk("t6.ew_pend_set", 32'(dut.ew_pend), 32'd1);
        bus.NS_vehicle_detect = 1'b0;
        bus.EW_vehicle_detect = 1'b0;
        @(negedge i_clk);
        for (int i = 1; i < 5; i++) begin
            check_state("t6_nsg_min", 1, i);
            @(negedge i_clk);
        end
        seg("t6_nsy", 2, 3);
        seg("t6_are", 3, 1);

        // 5: reset pulse at EW green timer=4 -> straight to all-red, pends cleared
        for (int i = 0; i < 5; i++) begin
            check_state("t5_ewg", 4, i);
            bus.NS_vehicle_detect = 1'b1;
            bus.EW_vehicle_detect = 1'b1;
            if (i == 4) begin
                chk("t5.ns_pend_pre", 32'(dut.ns_pend), 32'd1);
                i_rst_n = 1'b0;
            end
            @(negedge i_clk);
        end
        check_state("t5_rst", 0, 0);
        chk("t5.ns_pend", 32'(dut.ns_pend), 32'd0);
        chk("t5.ew_pend", 32'(dut.ew_pend), 32'd0);
        i_rst_n = 1'b1;
        bus.NS_vehicle_detect = 1'b0;
        bus.EW_vehicle_detect = 1'b0;
        @(negedge i_clk);
        seg("t5_resume", 1, 2);

        // 3: both detects held from reset -> 40-cycle max-out period, twice
        i_rst_n = 1'b0;
        bus.NS_vehicle_detect = 1'b1;
        bus.EW_vehicle_detect = 1'b1;
        @(negedge i_clk);
        check_state("t3_rst", 0, 0);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        for (int p = 0; p < 2; p++) begin
            seg("t3_nsg", 1, 20);
            seg("t3_nsy", 2, 3);
            seg("t3_are", 3, 1);
            seg("t3_ewg", 4, 12);
            seg("t3_ewy", 5, 3);
            seg("t3_arn", 0, 1);
        end
        check_state("t3_wrap", 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
